nested_loop_counter: RTL
========================

# nested_loop_counter

Multi-level cascaded loop counter, the parametrised successor to the single-level max counter. It generates LV nested loop indices, level 0 innermost, each with its own terminal value latched at start. Each level produces a carry, and the block supports one-shot (start/busy/done) and free-running wrap modes. It drives address and loop-index generation in datapath controllers and replaces hand-chained single counters.

## Interface
Parameters:
- LV, default 3: number of nested levels (≥1).
- DW, default 8: width of each level's index and terminal value.

Ports:
- clk  in  1: clock.
- rst_n  in  1: reset, asynchronous, active-low.
- start  in  1: begin a run; sampled only in IDLE.
- clr  in  1: synchronous abort/clear; highest priority.
- en  in  1: count-step enable (a stall when low); ignored outside RUN.
- wrap_mode  in  1: 1 = free-run (wrap forever); 0 = one-shot; sampled with start.
- max  in  LV×DW: per-level terminal values, packed with level i in bits [i*DW +: DW]; sampled with start.
- cnt  out  LV×DW: current indices, same packing.
- co  out  LV: co[i] = this step completes level i and all inner levels.
- last  out  1: equals co[LV-1]; the final step of a full pass.
- busy  out  1: high in RUN.
- done  out  1: one-cycle pulse after a one-shot run completes.

## Operation
- States: IDLE, RUN.
- IDLE:
  - On start & !clr: latch max→max_q and wrap_mode→mode_q, clear cnt to 0, go to RUN.
  - Otherwise hold.
- RUN: define step = en & busy.
  - co[0] = step & (cnt[0] == max_q[0]).
  - co[i] = co[i-1] & (cnt[i] == max_q[i]).
  - Level 0 advances on step. Level i>0 advances on co[i-1].
  - Advancing means: if cnt[i] == max_q[i] then 0, else cnt[i]+1.
  - A level never exceeds max_q[i]. max_q[i] = 0 is legal; that level stays 0 and passes its carry straight through.
- End of pass (co[LV-1] high):
  - mode_q = 1: all levels wrap to 0, stay in RUN, no done.
  - mode_q = 0: all levels go to 0, go to IDLE, done pulses the following cycle.
- clr in any state: cnt → 0, go to IDLE, busy → 0, no done. If clr coincides with the final step, clr still wins and no done is produced.
- start in RUN is ignored. Changes to max and wrap_mode during RUN have no effect.
- co and last are combinational from registered state and en. They are all 0 outside RUN.
- Steps per pass = Π(max_q[i]+1). Carry logic is DW-bit equality only; no wider arithmetic.

## Timing
- Reset values: cnt = 0, state IDLE, busy = 0, done = 0, max_q = 0, mode_q = 0.
  - Consequence: co = 0 and last = 0.
- start sampled at edge k: busy = 1 and cnt = 0 from k+1. The first step can occur in cycle k+1 when en = 1.
- Every step updates cnt at the next edge.
- One-shot final step at edge m: at m+1, busy = 0, cnt = 0, done = 1 for exactly one cycle.
  - A start in cycle m+1 is accepted, i.e. back-to-back runs with one IDLE cycle.
- en low holds cnt and forces co to 0. A stall between steps does not lose state.
- rst_n assertion mid-run returns all registers to reset values immediately. No done is produced.

## Test plan
- LV=2, DW=4, max={1,2} (level1 = 1, level0 = 2), one-shot, en = 1 constantly:
  - cnt(L1,L0) sequence must be 00, 01, 02, 10, 11, 12.
  - co[0] high on 02 and 12; last high on 12 only.
  - Next cycle: done = 1, busy = 0, cnt = 00.
  - Total 6 steps.
- Same config with en toggling 1,0,1,0…:
  - Same index sequence over 12 cycles.
  - co is never high while en = 0.
  - done 1 cycle after the 6th step.
- wrap_mode = 1, LV=3, max={0,1,1}:
  - Passes of 4 steps repeat with last every 4th step.
  - busy stays 1 and done is never asserted.
  - Level 2 stays 0 throughout.
- clr asserted at step 3 of a one-shot run:
  - Next cycle: cnt = 0, busy = 0, done = 0.
  - A start asserted in the same cycle as clr is ignored.
- Change max mid-run and pulse start during RUN:
  - Neither has any effect on the sequence.
  - The next run uses the max value present at its own start.
- rst_n low mid-run, async and between edges:
  - Outputs go to reset values immediately.
  - After release, a start runs a normal pass.

Source files
------------

// File: rtl/nested_loop_counter.sv
// Cascaded LV-level loop counter (level 0 innermost) with per-level terminal values
// latched at start; supports one-shot (start/busy/done) and free-running wrap modes.
module nested_loop_counter #(
    parameter int LV = 3,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic             en,
    input  logic             wrap_mode,
    input  logic [LV*DW-1:0] max,
    output logic [LV*DW-1:0] cnt,
    output logic [LV-1:0]    co,
    output logic             last,
    output logic             busy,
    output logic             done
);

    // Handshake: start is taken only while busy is low; busy stays high for the
    // whole run; done pulses for one cycle after a one-shot run ends (never on clr).
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LV*DW-1:0] cnt_q, cnt_d, max_q;
    logic             mode_q, done_q, done_d, load;
    logic             step, carry;
    logic [LV-1:0]    at_max, adv;

    // Carry chain: a level advances when every inner level completes this step.
    always_comb begin
        step   = en & (state_q == RUN);
        carry  = step;
        co     = '0;
        adv    = '0;
        at_max = '0;
        for (int i = 0; i < LV; i++) begin
            at_max[i] = (cnt_q[i*DW +: DW] == max_q[i*DW +: DW]);
            adv[i]    = carry;
            co[i]     = carry & at_max[i];
            carry     = co[i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load    = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < LV; i++) begin
                        if (adv[i]) begin
                            cnt_d[i*DW +: DW] = at_max[i] ? '0 : cnt_q[i*DW +: DW] + DW'(1);
                        end
                    end
                    // End of pass already wraps every level to 0 through the chain.
                    if (co[LV-1] && !mode_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q  <= '0;
            mode_q <= 1'b0;
        end else if (load) begin
            max_q  <= max;
            mode_q <= wrap_mode;
        end
    end

    assign cnt  = cnt_q;
    assign last = co[LV-1];
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule
